mem_stage_wait_ctrl: RTL and testbench
======================================

// Module: mem_stage_wait_ctrl
// PURPOSE
//  ARM pipeline MEM stage plus MEM/WB pipeline register. Sits directly downstream of the EX stage register.
//  Consumes the wb/mem enables, ALU result, Rm value and destination that the EX stage produces.
//  Performs LDR/STR on a word-addressed data memory with a programmable wait-state latency.
//  Drives a ready signal that freezes all upstream stages while an access is in flight.
// PARAMETERS
//  MEM_BASE     1024  byte address mapped to data-memory word 0
//  DEPTH_WORDS  64    number of 32-bit words in the data memory
//  WAIT_CYCLES  4     extra stall cycles per access; legal range 1..15
// PORTS
//  clk              in   1   clock; all state updates on rising edge
//  rst              in   1   synchronous, active-high reset
//  wb_en_in         in   1   write-back enable from the EX stage register
//  mem_r_en_in      in   1   load request
//  mem_w_en_in      in   1   store request
//  alu_res_in       in   32  byte address for mem ops; pass-through result otherwise
//  val_Rm_in        in   32  store data
//  dest_in          in   4   destination register
//  ready            out  1   0 = freeze PC, IF/ID/EX registers; upstream holds inputs stable
//  wb_en_hazard_out out  1   = wb_en_in (combinational, for hazard unit)
//  dest_hazard_out  out  4   = dest_in (combinational, for hazard unit)
//  wb_en_out        out  1   registered MEM/WB write-back enable
//  mem_r_en_out     out  1   registered; selects mem_data_out in WB mux
//  alu_res_out      out  32  registered ALU result
//  mem_data_out     out  32  registered load data
//  dest_out         out  4   registered destination
// BEHAVIOUR
//  - req = mem_r_en_in | mem_w_en_in.
//  - FSM has 3 states: IDLE, WAIT, DONE; cnt is 4 bits.
//    IDLE: if req -> WAIT, cnt <= WAIT_CYCLES-1; else stay in IDLE.
//    WAIT: if cnt==0 -> DONE; else cnt <= cnt-1.
//    DONE: -> IDLE unconditionally; the access commits on this edge.
//  - ready (combinational) = (IDLE & !req) | DONE; 0 in IDLE&req and in WAIT.
//  - A mem op holds ready=0 for WAIT_CYCLES+1 cycles; the result is registered on the DONE edge.
//    Total latency is WAIT_CYCLES+2 cycles. Non-mem ops have 1-cycle latency and no stall.
//  - Address: idx = (alu_res_in - MEM_BASE) >> 2; addr bits [1:0] are ignored.
//    in_range = alu_res_in >= MEM_BASE and idx < DEPTH_WORDS.
//  - Store at DONE edge: mem[idx] <= val_Rm_in if in_range; otherwise dropped silently.
//  - Load at DONE edge: mem_data_out <= mem[idx] if in_range, else 0.
//    Out-of-range accesses still take the full latency.
//  - Both mem_r_en_in and mem_w_en_in high: the store is performed and mem_data_out <= 0.
//  - MEM/WB register, when ready=1: wb_en/mem_r_en/alu_res/dest_out load from the inputs.
//    mem_data_out loads only on DONE; it holds otherwise.
//  - MEM/WB register, when ready=0: wb_en_out <= 0 and mem_r_en_out <= 0 (bubble).
//    alu_res_out, dest_out and mem_data_out hold.
//  - Reset (overrides everything, including mid-access): state=IDLE, cnt=0, all registered outputs 0.
//    A pending store is abandoned without writing. Memory array contents are NOT reset.
//  - Back-to-back mem ops: DONE->IDLE sees the next req and stalls again. No stall-free gap cycle
//    exists beyond the DONE cycle itself.
// TESTING
//  1 Non-mem: wb_en=1, alu_res=0x55, dest=3 -> ready stays 1; next cycle wb_en_out=1,
//    alu_res_out=0x55, dest_out=3.
//  2 Store then load: STR 0xDEADBEEF @1028, then LDR @1028 dest=5 (WAIT_CYCLES=4)
//    -> ready=0 for 5 cycles per op; mem_data_out=0xDEADBEEF, mem_r_en_out=1, dest_out=5
//    after the load's DONE edge.
//  3 Stall timing: LDR with WAIT_CYCLES=1 -> ready low exactly 2 cycles; wb_en_out=0
//    during the stall; result is valid 3 cycles after the request appears.
//  4 Out of range: STR 0x1234 @1020 and @(1024+4*64) -> no word modified.
//    LDR @1020 -> mem_data_out=0; full latency is still observed.
//  5 Reset mid-access: assert rst during WAIT of STR 0x77 @1032 -> next cycle state IDLE,
//    ready=1 (no req), outputs 0. A later LDR @1032 returns the pre-existing value, not 0x77.
//  6 Back-to-back: STR @1024, then STR @1028 held immediately after DONE -> two stall
//    windows of WAIT_CYCLES+1 separated by one ready=1 cycle; both words written.

Source files
------------

// File: rtl/mem_stage_wait_ctrl.sv
// mem_stage_wait_ctrl
//   ARM pipeline MEM stage together with the MEM/WB pipeline register. It performs LDR/STR on a
//   word-addressed data memory and adds a programmable wait-state latency to each access. While
//   an access is in flight, ready is held low so that the upstream stages freeze.
//
// Parameters
//   MEM_BASE     byte address that maps to data-memory word 0
//   DEPTH_WORDS  number of 32-bit words in the data memory
//   WAIT_CYCLES  extra stall cycles per access (1..15)
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   wb_en_in          write-back enable from the EX stage register
//   mem_r_en_in       load request
//   mem_w_en_in       store request
//   alu_res_in        byte address for memory ops; pass-through result otherwise
//   val_Rm_in         store data
//   dest_in           destination register
//   ready             0 freezes the PC and the IF/ID/EX registers
//   wb_en_hazard_out  combinational copy of wb_en_in for the hazard unit
//   dest_hazard_out   combinational copy of dest_in for the hazard unit
//   wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out
//                     registered MEM/WB outputs
module mem_stage_wait_ctrl #(
    parameter int unsigned MEM_BASE    = 1024,
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] val_Rm_in,
    input  logic [3:0]  dest_in,
    output logic        ready,
    output logic        wb_en_hazard_out,
    output logic [3:0]  dest_hazard_out,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic [31:0] alu_res_out,
    output logic [31:0] mem_data_out,
    output logic [3:0]  dest_out
);

    localparam int unsigned AddrW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CntInit = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic        req;
    logic        commit;
    logic [31:0] offset;
    logic        in_range;
    logic [AddrW-1:0] idx;
    logic [31:0] load_data;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        wb_en_q;
    logic        mem_r_en_q;
    logic [31:0] alu_res_q;
    logic [31:0] mem_data_q;
    logic [3:0]  dest_q;

    assign req              = mem_r_en_in | mem_w_en_in;
    assign wb_en_hazard_out = wb_en_in;
    assign dest_hazard_out  = dest_in;

    // Byte-address decode; the two low address bits select a byte lane and are ignored.
    assign offset   = alu_res_in - MEM_BASE;
    assign in_range = (alu_res_in >= MEM_BASE) && ({2'b00, offset[31:2]} < DEPTH_WORDS);
    assign idx      = offset[AddrW+1:2];

    logic unused_offset_lsbs;
    assign unused_offset_lsbs = ^offset[1:0];

    // Store-only and combined read/write accesses return zero so that WB never sees stale
    // load data tagged as the result of a store.
    assign load_data = (mem_r_en_in && !mem_w_en_in && in_range) ? mem_q[idx] : 32'h0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = !req;
                if (req) begin
                    state_d = StWait;
                    cnt_d   = CntInit;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                ready   = 1'b1;
                commit  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MEM/WB register: a stall inserts a bubble by clearing the enables, data fields hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            alu_res_q  <= 32'h0;
            mem_data_q <= 32'h0;
            dest_q     <= 4'h0;
        end else begin
            if (ready) begin
                wb_en_q    <= wb_en_in;
                mem_r_en_q <= mem_r_en_in;
                alu_res_q  <= alu_res_in;
                dest_q     <= dest_in;
            end else begin
                wb_en_q    <= 1'b0;
                mem_r_en_q <= 1'b0;
            end
            if (commit) begin
                mem_data_q <= load_data;
            end
        end
    end

    // Memory array has no reset; a reset during an access abandons the pending store.
    always_ff @(posedge clk) begin
        if (!rst && commit && mem_w_en_in && in_range) begin
            mem_q[idx] <= val_Rm_in;
        end
    end

    assign wb_en_out    = wb_en_q;
    assign mem_r_en_out = mem_r_en_q;
    assign alu_res_out  = alu_res_q;
    assign mem_data_out = mem_data_q;
    assign dest_out     = dest_q;

endmodule

// File: tb/tb_mem_stage_wait_ctrl.sv
// Randomised scoreboard bench for mem_stage_wait_ctrl. The driver issues transactions and pushes
// the expected ready pattern and MEM/WB result per transaction; a monitor pops and compares.
module tb_mem_stage_wait_ctrl;

    localparam int unsigned W     = 4;
    localparam int unsigned BASE  = 1024;
    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] alu_res_in, val_Rm_in;
    logic [3:0]  dest_in;
    logic        ready, wb_en_hazard_out, wb_en_out, mem_r_en_out;
    logic [3:0]  dest_hazard_out, dest_out;
    logic [31:0] alu_res_out, mem_data_out;

    always #5 clk = ~clk;

    mem_stage_wait_ctrl #(
        .MEM_BASE   (BASE),
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wb_en_in        (wb_en_in),
        .mem_r_en_in     (mem_r_en_in),
        .mem_w_en_in     (mem_w_en_in),
        .alu_res_in      (alu_res_in),
        .val_Rm_in       (val_Rm_in),
        .dest_in         (dest_in),
        .ready           (ready),
        .wb_en_hazard_out(wb_en_hazard_out),
        .dest_hazard_out (dest_hazard_out),
        .wb_en_out       (wb_en_out),
        .mem_r_en_out    (mem_r_en_out),
        .alu_res_out     (alu_res_out),
        .mem_data_out    (mem_data_out),
        .dest_out        (dest_out)
    );

    typedef struct packed {
        logic        wb;
        logic        rd;
        logic [31:0] alu;
        logic [31:0] data;
        logic [3:0]  dest;
    } res_t;

    res_t        resq[$];
    bit          rq[$];
    res_t        prev;
    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] mdl_data;
    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a memory op stalls W+1 cycles then has one ready cycle; others never stall.
    task automatic do_op(input logic wb, input logic rd, input logic wr, input logic [31:0] alu,
                         input logic [31:0] rm, input logic [3:0] dest);
        res_t        r;
        logic [31:0] idx;
        bit          inr;
        int          n;
        idx = (alu - BASE) >> 2;
        inr = (alu >= BASE) && (idx < DEPTH);
        if (rd || wr) begin
            mdl_data = (rd && !wr && inr) ? mdl_mem[idx[5:0]] : 32'h0;
            if (wr && inr) mdl_mem[idx[5:0]] = rm;
            for (int i = 0; i < W + 1; i++) rq.push_back(1'b0);
            rq.push_back(1'b1);
            n = W + 2;
        end else begin
            rq.push_back(1'b1);
            n = 1;
        end
        r.wb = wb; r.rd = rd; r.alu = alu; r.data = mdl_data; r.dest = dest;
        resq.push_back(r);
        wb_en_in = wb; mem_r_en_in = rd; mem_w_en_in = wr;
        alu_res_in = alu; val_Rm_in = rm; dest_in = dest;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int i;
        do_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        i = 0;
        while (rq.size() > 0 && i < 200) begin
            @(posedge clk);
            i++;
        end
        check("drain_timeout", rq.size(), 0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, {31'h0, ready}, 32'h1);
        check({tag, "_wb_en"}, {31'h0, wb_en_out}, 32'h0);
        check({tag, "_mem_r_en"}, {31'h0, mem_r_en_out}, 32'h0);
        check({tag, "_alu_res"}, alu_res_out, 32'h0);
        check({tag, "_mem_data"}, mem_data_out, 32'h0);
        check({tag, "_dest"}, {28'h0, dest_out}, 32'h0);
    endtask

    // Monitor
    initial begin
        bit   e;
        res_t r;
        forever begin
            @(negedge clk);
            if (mon_en && rq.size() > 0) begin
                e = rq.pop_front();
                check("ready", {31'h0, ready}, {31'h0, e});
                check("wb_en_hazard", {31'h0, wb_en_hazard_out}, {31'h0, wb_en_in});
                check("dest_hazard", {28'h0, dest_hazard_out}, {28'h0, dest_in});
                @(posedge clk);
                #1;
                if (e) begin
                    if (resq.size() == 0) begin
                        check("result_queue_empty", 32'h1, 32'h0);
                    end else begin
                        r = resq.pop_front();
                        check("wb_en_out", {31'h0, wb_en_out}, {31'h0, r.wb});
                        check("mem_r_en_out", {31'h0, mem_r_en_out}, {31'h0, r.rd});
                        check("alu_res_out", alu_res_out, r.alu);
                        check("mem_data_out", mem_data_out, r.data);
                        check("dest_out", {28'h0, dest_out}, {28'h0, r.dest});
                        prev = r;
                    end
                end else begin
                    check("bubble_wb_en", {31'h0, wb_en_out}, 32'h0);
                    check("bubble_mem_r_en", {31'h0, mem_r_en_out}, 32'h0);
                    check("hold_alu_res", alu_res_out, prev.alu);
                    check("hold_mem_data", mem_data_out, prev.data);
                    check("hold_dest", {28'h0, dest_out}, {28'h0, prev.dest});
                end
            end
        end
    end

    function automatic logic [31:0] rand_addr();
        logic [31:0] oor [5];
        oor[0] = 32'd1020; oor[1] = BASE + 4 * DEPTH; oor[2] = 32'h0;
        oor[3] = 32'hFFFF_FFFC; oor[4] = BASE - 1;
        if ($urandom_range(0, 9) == 0) return oor[$urandom_range(0, 4)];
        return BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3);
    endfunction

    initial begin
        int k;
        prev = '0;
        mdl_data = 32'h0;
        rst = 1'b1;
        wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
        alu_res_in = 32'h0; val_Rm_in = 32'h0; dest_in = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Give every word a known value
        for (int i = 0; i < DEPTH; i++) do_op(1'b0, 1'b0, 1'b1, BASE + 4 * i, $urandom, 4'h0);

        do_op(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3);
        do_op(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 4'd0);
        do_op(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd5);
        do_op(1'b0, 1'b0, 1'b1, 32'd1020, 32'h1234, 4'd0);
        do_op(1'b0, 1'b0, 1'b1, BASE + 4 * DEPTH, 32'h1234, 4'd0);
        do_op(1'b1, 1'b1, 1'b0, 32'd1020, 32'h0, 4'd6);
        do_op(1'b1, 1'b1, 1'b0, BASE, 32'h0, 4'd1);
        do_op(1'b1, 1'b1, 1'b0, BASE + 4 * (DEPTH - 1), 32'h0, 4'd2);
        do_op(1'b0, 1'b0, 1'b1, 32'd1024, 32'hA5A5_0001, 4'd0);
        do_op(1'b0, 1'b0, 1'b1, 32'd1028, 32'hA5A5_0002, 4'd0);
        do_op(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd8);
        do_op(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd9);
        do_op(1'b1, 1'b1, 1'b1, 32'd1040, 32'h0000_ABCD, 4'd7);
        do_op(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd7);

        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 19);
            if (k < 8)
                do_op(1'($urandom), 1'b0, 1'b0, $urandom, $urandom, 4'($urandom));
            else if (k < 13)
                do_op(1'($urandom), 1'b1, 1'b0, rand_addr(), $urandom, 4'($urandom));
            else if (k < 18)
                do_op(1'($urandom), 1'b0, 1'b1, rand_addr(), $urandom, 4'($urandom));
            else
                do_op(1'($urandom), 1'b1, 1'b1, rand_addr(), $urandom, 4'($urandom));
        end
        drain();

        // Reset in the middle of a store: the write must be abandoned
        mon_en = 1'b0;
        wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b1;
        alu_res_in = 32'd1032; val_Rm_in = 32'h77; dest_in = 4'h0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        mem_w_en_in = 1'b0; alu_res_in = 32'h0; val_Rm_in = 32'h0;
        @(posedge clk);
        #1;
        check_reset_state("midreset");
        #1;
        rst = 1'b0;
        prev = '0;
        mdl_data = 32'h0;
        mon_en = 1'b1;
        do_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd9);
        do_op(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 4'd4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
